// File: rtl/tmds_pkg.sv
// Shared constants for the TMDS DDR serializer: word geometry and channel lanes.
package tmds_pkg;

  localparam int TMDS_WORD_W = 10;
  localparam int TMDS_SLOTS  = 5;
  localparam int CNT_W       = 3;

  // Slot index in which a fresh word is captured (the last slot of a word).
  localparam logic [CNT_W-1:0] LOAD_SLOT = CNT_W'(TMDS_SLOTS - 1);

  localparam int CH_R   = 0;
  localparam int CH_G   = 1;
  localparam int CH_B   = 2;
  localparam int NUM_CH = 3;

endpackage

// File: rtl/tmds_ddr_shifter.sv
// One TMDS lane: captures a 10-bit word on load and feeds it out two bits per
// cycle, LSB first, as a rising/falling pair for a DDR output cell.
module tmds_ddr_shifter
  import tmds_pkg::*;
(
  input  logic                   serclk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [TMDS_WORD_W-1:0] word,
  output logic                   rising,
  output logic                   falling
);

  // Bits 9..2 still waiting to go out; bits 1..0 leave straight from the input.
  logic [TMDS_WORD_W-3:0] sh;

  // Load the pair for slot 0 directly from the word, otherwise shift by two.
  always_ff @(posedge serclk) begin
    if (rst) begin
      sh      <= '0;
      rising  <= 1'b0;
      falling <= 1'b0;
    end else if (load) begin
      rising  <= word[0];
      falling <= word[1];
      sh      <= word[TMDS_WORD_W-1:2];
    end else begin
      rising  <= sh[0];
      falling <= sh[1];
      sh      <= sh >> 2;
    end
  end

endmodule

// File: rtl/tmds_ddr_serializer.sv
// DVI serializer: three TMDS data lanes plus the TMDS clock channel, all in the
// serclk domain at two bits per channel per cycle.
//
// Strobe semantics: there is no handshake. load is high for one cycle in every
// five; the r/g/b values present at the edge ending that cycle are the next
// word sent, and values at any other time are ignored. The source cannot stall.
module tmds_ddr_serializer
  import tmds_pkg::*;
(
  input  logic                   serclk,
  input  logic                   rst,
  input  logic [TMDS_WORD_W-1:0] r,
  input  logic [TMDS_WORD_W-1:0] g,
  input  logic [TMDS_WORD_W-1:0] b,
  output logic                   load,
  output logic [NUM_CH-1:0]      rising,
  output logic [NUM_CH-1:0]      falling,
  output logic                   clk
);

  logic [CNT_W-1:0] cnt;

  // Slot counter 0..4; reset parks it on the load slot so the first live edge captures.
  always_ff @(posedge serclk) begin
    if (rst) begin
      cnt <= LOAD_SLOT;
    end else if (cnt == LOAD_SLOT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign load = (cnt == LOAD_SLOT);

  // TMDS clock: high while slots 0-2 are on the pins, so its rising edge lines up with bit 0.
  always_ff @(posedge serclk) begin
    if (rst) begin
      clk <= 1'b0;
    end else begin
      clk <= (cnt == LOAD_SLOT) || (cnt == CNT_W'(0)) || (cnt == CNT_W'(1));
    end
  end

  tmds_ddr_shifter u_lane_r (
    .serclk  (serclk),
    .rst     (rst),
    .load    (load),
    .word    (r),
    .rising  (rising[CH_R]),
    .falling (falling[CH_R])
  );

  tmds_ddr_shifter u_lane_g (
    .serclk  (serclk),
    .rst     (rst),
    .load    (load),
    .word    (g),
    .rising  (rising[CH_G]),
    .falling (falling[CH_G])
  );

  tmds_ddr_shifter u_lane_b (
    .serclk  (serclk),
    .rst     (rst),
    .load    (load),
    .word    (b),
    .rising  (rising[CH_B]),
    .falling (falling[CH_B])
  );

endmodule

// File: tb/tb_tmds_ddr_serializer.sv
// Bench for tmds_ddr_serializer: directed words from the test plan, a mid-word
// reset, then randomized words and resets checked against a slot-level model.
module tb_tmds_ddr_serializer;
  import tmds_pkg::*;

  // ---------------- clock / reset ----------------
  logic                   serclk = 1'b0;
  logic                   rst    = 1'b1;
  logic [TMDS_WORD_W-1:0] r = '0, g = '0, b = '0;
  logic                   load;
  logic [NUM_CH-1:0]      rising, falling;
  logic                   clk;

  always #5 serclk = ~serclk;

  tmds_ddr_serializer dut (
    .serclk  (serclk),
    .rst     (rst),
    .r       (r),
    .g       (g),
    .b       (b),
    .load    (load),
    .rising  (rising),
    .falling (falling),
    .clk     (clk)
  );

  // ---------------- scoreboard ----------------
  // Each entry is what the pins should show for one serclk cycle:
  // {load, clk, falling[2:0], rising[2:0]}.
  localparam int EW = 8;
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expand a captured word triple into the five per-cycle pin patterns.
  // Slot k carries bits 2k (rising) and 2k+1 (falling); TMDS clock is high for slots 0-2.
  task automatic push_word(input logic [TMDS_WORD_W-1:0] wr, wg, wb);
    logic [TMDS_WORD_W-1:0] w [NUM_CH];
    w[CH_R] = wr;
    w[CH_G] = wg;
    w[CH_B] = wb;
    for (int k = 0; k < TMDS_SLOTS; k++) begin
      logic [EW-1:0] e;
      e = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        e[c]     = w[c][2*k];
        e[3 + c] = w[c][2*k + 1];
      end
      e[6] = (k <= 2);
      e[7] = (k == TMDS_SLOTS - 1);
      exp_q.push_back(e);
    end
  endtask

  // ---------------- driver ----------------
  // Apply inputs for one cycle, advance the model at the edge, then compare.
  task automatic step(input logic rv, input logic [TMDS_WORD_W-1:0] rr, gg, bb);
    logic [EW-1:0] e;
    @(negedge serclk);
    rst = rv;
    r   = rr;
    g   = gg;
    b   = bb;
    @(posedge serclk);
    if (rv) begin
      exp_q.delete();
      e = 8'b1000_0000;  // outputs cleared, clk low, load held high
    end else begin
      // A new word is captured exactly when the previous one has fully drained.
      if (exp_q.size() == 0) push_word(rr, gg, bb);
      e = exp_q.pop_front();
    end
    #1;
    check("rising",  32'(rising),  32'(e[2:0]));
    check("falling", 32'(falling), 32'(e[5:3]));
    check("clk",     32'(clk),     32'(e[6]));
    check("load",    32'(load),    32'(e[7]));
  endtask

  task automatic hold_word(input int cycles, input logic [TMDS_WORD_W-1:0] rr, gg, bb);
    for (int i = 0; i < cycles; i++) step(1'b0, rr, gg, bb);
  endtask

  function automatic logic [TMDS_WORD_W-1:0] rnd_word();
    return TMDS_WORD_W'($urandom_range(0, (1 << TMDS_WORD_W) - 1));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int guard;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) step(1'b1, rnd_word(), rnd_word(), rnd_word());

    // Test-plan red words back to back, then channel independence.
    hold_word(5, 10'b1101010100, rnd_word(), rnd_word());
    hold_word(5, 10'b0010101011, rnd_word(), rnd_word());
    hold_word(10, 10'h000, 10'h3FF, 10'h155);

    // Directed spot checks of the test-plan red bit sequence for one word.
    begin
      logic [TMDS_SLOTS-1:0] seen_r, seen_f;
      seen_r = '0;
      seen_f = '0;
      for (int k = 0; k < TMDS_SLOTS; k++) begin
        step(1'b0, 10'b1101010100, 10'h000, 10'h000);
        seen_r[k] = rising[CH_R];
        seen_f[k] = falling[CH_R];
      end
      check("plan_rise_r0", 32'(seen_r), 32'(5'b11110));
      check("plan_fall_r0", 32'(seen_f), 32'(5'b10000));
    end

    // Mid-word reset: walk to slot 2, reset for one cycle, then resume.
    hold_word(1, rnd_word(), rnd_word(), rnd_word());
    guard = 0;
    while (exp_q.size() != 2 && guard < 10) begin
      step(1'b0, rnd_word(), rnd_word(), rnd_word());
      guard++;
    end
    check("reach_slot2", 32'(exp_q.size()), 32'd2);
    step(1'b1, rnd_word(), rnd_word(), rnd_word());
    hold_word(5, 10'b1111100001, 10'h2AA, 10'h0F0);

    // Randomized: inputs change every cycle, occasional resets of 1-2 cycles.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        int n;
        n = $urandom_range(1, 2);
        for (int j = 0; j < n; j++) step(1'b1, rnd_word(), rnd_word(), rnd_word());
      end else begin
        step(1'b0, rnd_word(), rnd_word(), rnd_word());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
